// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO consumer: packs PACK entries per output word (first entry in lane 0),
// streams words on valid/ready, and drains a partial word with a lane-keep mask on flush.
module fifo_rd_packer #(
  parameter int DSIZE = 8,
  parameter int PACK  = 4
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  output logic                  rq,
  input  logic [DSIZE-1:0]      read_data,
  input  logic                  flush,
  output logic [DSIZE*PACK-1:0] out_data,
  output logic [PACK-1:0]       out_keep,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           word_cnt
);

  localparam int W  = DSIZE * PACK;
  localparam int FW = $clog2(PACK + 1);
  localparam logic [FW-1:0] PACK_F = FW'(PACK);
  localparam logic [FW:0]   PACK_C = (FW + 1)'(PACK);

  logic [W-1:0]     r_asm;
  logic [FW-1:0]    r_fill;
  logic             r_inflight;
  logic             r_flush_pend;
  logic [W-1:0]     r_out_data;
  logic [PACK-1:0]  r_out_keep;
  logic             r_out_valid;
  logic [15:0]      r_word_cnt;

  logic             w_slot_free;
  logic [FW:0]      w_occ;
  logic             w_rq;
  logic [FW-1:0]    w_fill_cap;
  logic [W-1:0]     w_asm_cap;
  logic             w_flush_go;
  logic             w_emit;

  function automatic logic [PACK-1:0] keep_mask(input logic [FW-1:0] n);
    logic [PACK-1:0] m;
    m = '0;
    for (int i = 0; i < PACK; i++) begin
      if (FW'(i) < n) m[i] = 1'b1;
      else            m[i] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [W-1:0] lane_write(input logic [W-1:0] a,
                                              input logic [FW-1:0] idx,
                                              input logic [DSIZE-1:0] d);
    logic [W-1:0] r;
    r = a;
    for (int i = 0; i < PACK; i++) begin
      if (idx == FW'(i)) r[i*DSIZE +: DSIZE] = d;
      else               r[i*DSIZE +: DSIZE] = a[i*DSIZE +: DSIZE];
    end
    return r;
  endfunction

  // Request, capture and transfer decisions for the coming edge
  always_comb begin
    w_slot_free = ~r_out_valid | out_ready;
    w_occ       = {1'b0, r_fill} + {{FW{1'b0}}, r_inflight};
    w_rq        = rrst_n & ~rempty & ~r_flush_pend & (w_occ < PACK_C);
    if (r_inflight) begin
      w_fill_cap = r_fill + {{(FW-1){1'b0}}, 1'b1};
      w_asm_cap  = lane_write(r_asm, r_fill, read_data);
    end else begin
      w_fill_cap = r_fill;
      w_asm_cap  = r_asm;
    end
    // A flush only completes once no pop is pending, so no entry lands after the drain.
    w_flush_go = (r_flush_pend | flush) & ~r_inflight & ~w_rq & w_slot_free;
    w_emit     = w_slot_free & ((w_fill_cap == PACK_F) | (w_flush_go & (r_fill != '0)));
  end

  assign rq        = w_rq;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_valid = r_out_valid;
  assign word_cnt  = r_word_cnt;

  // Assembly, output register, flush tracking and accepted-word counter
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_asm        <= '0;
      r_fill       <= '0;
      r_inflight   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_out_valid  <= 1'b0;
      r_word_cnt   <= 16'd0;
    end else begin
      r_inflight <= w_rq;
      if (w_emit) begin
        r_out_data  <= w_asm_cap;
        r_out_keep  <= keep_mask(w_fill_cap);
        r_out_valid <= 1'b1;
        r_asm       <= '0;
        r_fill      <= '0;
      end else begin
        if (r_out_valid & out_ready) r_out_valid <= 1'b0;
        else                         r_out_valid <= r_out_valid;
        r_asm  <= w_asm_cap;
        r_fill <= w_fill_cap;
      end
      if (w_flush_go)  r_flush_pend <= 1'b0;
      else if (flush)  r_flush_pend <= 1'b1;
      else             r_flush_pend <= r_flush_pend;
      if (r_out_valid & out_ready) r_word_cnt <= r_word_cnt + 16'd1;
      else                         r_word_cnt <= r_word_cnt;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a queue-backed FIFO model feeds the DUT and
// accepted words are logged at the falling edge for comparison with hand-computed values.
module tb_fifo_rd_packer;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        rempty;
  logic        rq;
  logic [7:0]  read_data = 8'h00;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] word_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo_q[$];
  int          fifo_cnt = 0;
  logic        force_empty = 1'b0;
  logic        rq_q = 1'b0;
  logic        rq_log[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];

  assign rempty = (fifo_cnt == 0) | force_empty;

  fifo_rd_packer #(.DSIZE(8), .PACK(4)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rq(rq), .read_data(read_data),
    .flush(flush), .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready), .word_cnt(word_cnt)
  );

  always #5 rclk = ~rclk;

  always @(negedge rclk) begin
    rq_q = rq;
    rq_log.push_back(rq);
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_keep.push_back(out_keep);
    end
  end

  // FIFO model: a pop seen before the edge presents its data just after the edge
  always @(posedge rclk) begin
    #1;
    if (rq_q) begin
      checks++;
      if (fifo_cnt == 0) begin
        errors++;
        $display("FAIL fifo_underflow: rq=1 required rempty=0 but model fifo_cnt=%0d", fifo_cnt);
      end else begin
        read_data = fifo_q.pop_front();
        fifo_cnt--;
      end
      rq_q = 1'b0;
    end
  end

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    fifo_cnt++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic clear_logs();
    got_data.delete();
    got_keep.delete();
    rq_log.delete();
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    tick(1);
    push(8'h99);
    tick(2);
    @(negedge rclk);
    checks++; if (rq !== 1'b0) begin errors++; $display("FAIL reset_rq: got %b want 0", rq); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", out_data); end
    checks++; if (out_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %h want 0", out_keep); end
    checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", word_cnt); end
    @(posedge rclk); #1;
    fifo_q.delete();
    fifo_cnt = 0;
    rrst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    logic [9:0] rpat;
    logic [9:0] vpat;
    clear_logs();
    push(8'h11); push(8'h12); push(8'h13); push(8'h14);
    for (int k = 0; k < 10; k++) begin
      @(negedge rclk);
      rpat[k] = rq;
      vpat[k] = out_valid;
    end
    checks++; if (rpat !== 10'b0000001111) begin errors++; $display("FAIL single_rq_pattern: got %b want 0000001111", rpat); end
    checks++; if (vpat !== 10'b0000100000) begin errors++; $display("FAIL single_valid_latency: got %b want 0000100000", vpat); end
    checks++; if (got_data.size() != 1) begin errors++; $display("FAIL single_count: got %0d words want 1", got_data.size()); end
    checks++; if (got_data.size() < 1 || got_data[0] !== 32'h14131211) begin errors++; $display("FAIL single_data: got %h want 14131211", (got_data.size() > 0) ? got_data[0] : 32'hx); end
    checks++; if (got_keep.size() < 1 || got_keep[0] !== 4'hF) begin errors++; $display("FAIL single_keep: got %h want F", (got_keep.size() > 0) ? got_keep[0] : 4'hx); end
    checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL single_word_cnt: got %0d want 1", word_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [3];
    logic [15:0] act_pat;
    exp_w[0] = 32'h23222120; exp_w[1] = 32'h27262524; exp_w[2] = 32'h2B2A2928;
    @(posedge rclk); #1;
    clear_logs();
    for (int i = 0; i < 12; i++) push(8'h20 + 8'(i));
    tick(22);
    for (int k = 0; k < 16; k++) act_pat[k] = rq_log[k];
    // bubble after every 4th request, three groups
    checks++; if (act_pat !== 16'b0011110111101111) begin errors++; $display("FAIL stream_rq_pattern: got %b want 0011110111101111", act_pat); end
    checks++; if (got_data.size() != 3) begin errors++; $display("FAIL stream_count: got %0d words want 3", got_data.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp_w[i] || got_keep[i] !== 4'hF) begin
        errors++;
        $display("FAIL stream_word%0d: got %h want %h keep F", i, (i < got_data.size()) ? got_data[i] : 32'hx, exp_w[i]);
      end
    end
    checks++; if (word_cnt !== 16'd4) begin errors++; $display("FAIL stream_word_cnt: got %0d want 4", word_cnt); end
  endtask

  task automatic test_flush();
    clear_logs();
    push(8'hA1); push(8'hA2); push(8'hA3);
    tick(8);
    flush = 1'b1;
    @(negedge rclk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_early_valid: got %b want 0", out_valid); end
    @(posedge rclk); #1;
    flush = 1'b0;
    @(negedge rclk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h00A3A2A1) begin errors++; $display("FAIL flush_data: got %h want 00A3A2A1", out_data); end
    checks++; if (out_keep !== 4'h7) begin errors++; $display("FAIL flush_keep: got %h want 7", out_keep); end
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(4);
    checks++; if (got_data.size() != 1) begin errors++; $display("FAIL flush_empty_no_output: got %0d words want 1", got_data.size()); end
    checks++; if (word_cnt !== 16'd5) begin errors++; $display("FAIL flush_word_cnt: got %0d want 5", word_cnt); end
  endtask

  task automatic test_backpressure();
    int rq_ones;
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
    tick(15);
    @(negedge rclk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h33323130) begin errors++; $display("FAIL bp_hold_first: got v=%b %h want v=1 33323130", out_valid, out_data); end
    tick(5);
    @(negedge rclk);
    checks++; if (out_data !== 32'h33323130 || out_keep !== 4'hF) begin errors++; $display("FAIL bp_stable: got %h keep %h want 33323130 keep F", out_data, out_keep); end
    checks++; if (fifo_cnt != 2) begin errors++; $display("FAIL bp_rq_stop: fifo left %0d want 2", fifo_cnt); end
    rq_ones = 0;
    foreach (rq_log[k]) rq_ones += int'(rq_log[k]);
    checks++; if (rq_ones != 8) begin errors++; $display("FAIL bp_pop_count: got %0d want 8", rq_ones); end
    checks++; if (got_data.size() != 0) begin errors++; $display("FAIL bp_no_accept: got %0d words want 0", got_data.size()); end
    @(posedge rclk); #1;
    out_ready = 1'b1;
    tick(8);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(4);
    checks++; if (got_data.size() != 3) begin errors++; $display("FAIL bp_count: got %0d words want 3", got_data.size()); end
    checks++; if (got_data.size() < 1 || got_data[0] !== 32'h33323130) begin errors++; $display("FAIL bp_word0: got %h want 33323130", (got_data.size() > 0) ? got_data[0] : 32'hx); end
    checks++; if (got_data.size() < 2 || got_data[1] !== 32'h37363534 || got_keep[1] !== 4'hF) begin errors++; $display("FAIL bp_word1: got %h want 37363534", (got_data.size() > 1) ? got_data[1] : 32'hx); end
    checks++; if (got_data.size() < 3 || got_data[2] !== 32'h00003938 || got_keep[2] !== 4'h3) begin errors++; $display("FAIL bp_tail: got %h keep %h want 00003938 keep 3", (got_data.size() > 2) ? got_data[2] : 32'hx, (got_keep.size() > 2) ? got_keep[2] : 4'hx); end
    checks++; if (word_cnt !== 16'd8) begin errors++; $display("FAIL bp_word_cnt: got %0d want 8", word_cnt); end
  endtask

  task automatic test_rempty_toggle();
    clear_logs();
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    for (int k = 0; k < 30; k++) begin
      force_empty = ~force_empty;
      tick(1);
    end
    force_empty = 1'b0;
    tick(4);
    checks++; if (got_data.size() != 2) begin errors++; $display("FAIL toggle_count: got %0d words want 2", got_data.size()); end
    checks++; if (got_data.size() < 1 || got_data[0] !== 32'h43424140) begin errors++; $display("FAIL toggle_word0: got %h want 43424140", (got_data.size() > 0) ? got_data[0] : 32'hx); end
    checks++; if (got_data.size() < 2 || got_data[1] !== 32'h47464544) begin errors++; $display("FAIL toggle_word1: got %h want 47464544", (got_data.size() > 1) ? got_data[1] : 32'hx); end
    checks++; if (fifo_cnt != 0 || word_cnt !== 16'd10) begin errors++; $display("FAIL toggle_drain: fifo %0d cnt %0d want 0 and 10", fifo_cnt, word_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    push(8'h50); push(8'h51); push(8'h52); push(8'h53);
    tick(3);
    rrst_n = 1'b0;
    @(negedge rclk);
    checks++; if (rq !== 1'b0) begin errors++; $display("FAIL midrst_rq: got %b want 0", rq); end
    @(posedge rclk); #1;
    rrst_n = 1'b1;
    @(negedge rclk);
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'h0) begin errors++; $display("FAIL midrst_outputs: got v=%b %h keep %h want all 0", out_valid, out_data, out_keep); end
    checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0d want 0", word_cnt); end
    @(posedge rclk); #1;
    push(8'h60); push(8'h61); push(8'h62);
    tick(10);
    checks++; if (got_data.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d words want 1", got_data.size()); end
    checks++; if (got_data.size() < 1 || got_data[0] !== 32'h62616053 || got_keep[0] !== 4'hF) begin errors++; $display("FAIL midrst_word: got %h want 62616053", (got_data.size() > 0) ? got_data[0] : 32'hx); end
    checks++; if (word_cnt !== 16'd1 || fifo_cnt != 0) begin errors++; $display("FAIL midrst_tail: cnt %0d fifo %0d want 1 and 0", word_cnt, fifo_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_backpressure();
    test_rempty_toggle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the team's async FIFO, clocked in the read domain. It pops DSIZE-bit entries through the FIFO read port (rq / read_data / rempty). It packs PACK consecutive entries into one wide word, first-popped entry in the least significant lane. Each word goes out on a valid/ready stream, and a flush request drains a partial word with a lane-keep mask.

## Interface
- DSIZE, 8, FIFO entry width
- PACK, 4, entries per output word (2..8)
- rclk  in  1  read-domain clock, all logic on rising edge
- rrst_n  in  1  reset: synchronous, active-low
- rempty  in  1  FIFO empty flag (read domain)
- rq  out  1  FIFO read request, combinational
- read_data  in  DSIZE  FIFO read data, valid the cycle after rq is sampled high
- flush  in  1  single-cycle request to emit the partial word
- out_data  out  DSIZE*PACK  packed word; lane i = bits [i*DSIZE +: DSIZE]
- out_keep  out  PACK  lane valid mask for out_data
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- word_cnt  out  16  count of accepted output words, wraps 0xFFFF→0

## Operation
- State: assembly register asm (PACK lanes), fill (0..PACK), inflight (= rq registered), flush_pend, output register (out_data/out_keep/out_valid), word_cnt.
- rq = rrst_n & ~rempty & ~flush_pend & (fill + inflight < PACK). It is never high while rrst_n is low.
- Capture: when inflight=1, read_data is written to lane fill, and fill increments.
- Complete: if the capture fills lane PACK-1 and the output slot is free, load the output register in that same edge. Set out_keep = all ones and fill←0. The output slot is free when ~out_valid | out_ready.
- If the output slot is busy, the full word stays in asm with fill=PACK. rq stays low. Transfer happens on the first edge where the slot is free.
- Output hold: out_data/out_keep are stable while out_valid & ~out_ready. out_valid clears on accept unless a new word loads in the same edge.
- word_cnt increments on each edge where out_valid & out_ready.
- Flush handling:
  - flush sets flush_pend and blocks new rq.
  - Once inflight=0 and the slot is free:
    - fill>0: emit asm with out_keep = (1<<fill)-1 and unused lanes zero. fill←0, flush_pend←0.
    - fill=0: flush_pend←0 with no output.
  - flush while flush_pend=1 is ignored.
  - flush in the same cycle as the final-lane capture: the full word is emitted normally, then the flush completes with no output.
- Unused asm lanes are zeroed when a word transfers.
- Reset (rrst_n low at a rising edge), from any state including mid-word or mid-flush:
  - out_valid=0, out_data=0, out_keep=0, fill=0, inflight=0, flush_pend=0, word_cnt=0.
  - The partial word and any in-flight entry are discarded.

## Timing
- rq high in cycle c means read_data is valid in cycle c+1 and captured at the end of c+1.
- Steady stream with out_ready=1:
  - rq high for PACK cycles, low for 1 cycle.
  - Throughput is PACK entries per PACK+1 cycles.
  - out_valid rises in the cycle after the final entry's data cycle.
- Minimum latency from the first rq to out_valid is PACK+1 cycles.
- Flush latency: with inflight=0 and the slot free, out_valid rises the cycle after flush. Otherwise it rises one cycle after the blocking condition clears.
- rempty is sampled each cycle. If it rises, rq drops in that same cycle and no entry is lost.

## Test plan
- FIFO model holds 0x11,0x12,0x13,0x14 and out_ready=1 → one word 0x14131211, out_keep=0xF, rq high 4 cycles, word_cnt=1.
- 12 entries 0x20..0x2B with out_ready=1:
  - words 0x23222120, 0x27262524, 0x2B2A2928;
  - a single rq bubble after every 4th request.
- 3 entries 0xA1,0xA2,0xA3, then flush → out_data=0x00A3A2A1, out_keep=0x7; a second flush with fill=0 produces no output.
- out_ready held low while 8 entries are available:
  - first word is held stable, second word waits in asm, rq stops after 8 pops;
  - raising out_ready delivers both words in order.
- rempty toggling every other cycle (FIFO empties mid-word) → no duplicated or dropped entries, word values are correct.
- rrst_n pulsed low for 1 cycle with fill=2 and inflight=1 → all outputs 0, fill=0, and the next 4 entries form a clean word.
